// File: rtl/instr_fetch_pkg.sv
// Shared encodings and default sizes for the instruction fetch sequencer.
package instr_fetch_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_PC_WIDTH    = 8;
  localparam int DEF_STACK_DEPTH = 4;

  // jmp_mode encodings driven by the decoder
  typedef enum logic [1:0] {
    JMP_ABS  = 2'b00,
    JMP_BASE = 2'b01,
    JMP_RSV  = 2'b10,
    JMP_RET  = 2'b11
  } jmp_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10
  } state_e;

endpackage

// File: rtl/instr_fetch_link_stack.sv
// Link/return stack: LIFO of return addresses with full/empty detection.
// A push while full or a pop while empty is dropped and flagged for one cycle.
module instr_fetch_link_stack
  import instr_fetch_pkg::*;
#(
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] top,
  output logic                ovf_det,
  output logic                unf_det
);

  localparam int AW  = $clog2(STACK_DEPTH);
  localparam int SPW = AW + 1;
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  logic [STACK_DEPTH-1:0][PC_WIDTH-1:0] mem;
  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_dec;
  logic           full, empty, do_push, do_pop;

  assign full    = (sp == SP_FULL);
  assign empty   = (sp == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign ovf_det = push & full;
  assign unf_det = pop & empty;
  assign sp_dec  = sp - SP_ONE;
  // an empty stack reads as address 0 so RET still lands somewhere defined
  assign top     = empty ? '0 : mem[sp_dec[AW-1:0]];

  // storage needs no reset: entries above sp are never read
  always_ff @(posedge clk) begin
    if (do_push) mem[sp[AW-1:0]] <= push_data;
  end

  // entry count; flush wins over any push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sp <= '0;
    else if (flush)   sp <= '0;
    else if (do_push) sp <= sp + SP_ONE;
    else if (do_pop)  sp <= sp_dec;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction sequencer: owns pc, base register and link stack, fetches
// {instr,arg} over a req/ack handshake and executes one instruction per EXEC.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 mem_req,
  output logic [PC_WIDTH-1:0]  mem_addr,
  input  logic                 mem_ack,
  input  logic [2*WIDTH-1:0]   mem_rdata,
  output logic [WIDTH-1:0]     instr,
  output logic [WIDTH-1:0]     arg,
  output logic                 instr_valid,
  output logic [PC_WIDTH-1:0]  pc,
  input  logic                 pc_rst,
  input  logic                 pc_ld,
  input  logic [1:0]           jmp_mode,
  input  logic [WIDTH-1:0]     base_reg_offset,
  input  logic                 base_reg_ld,
  input  logic [WIDTH-1:0]     base_reg_data,
  input  logic                 lr_ld,
  output logic                 stack_ovf,
  output logic                 stack_unf
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  state_e              state;
  logic [WIDTH-1:0]    base;
  logic [PC_WIDTH-1:0] next_pc, off_pc, base_pc, stk_top;
  logic                exec, push, pop, flush, ovf_det, unf_det;

  assign exec     = (state == ST_EXEC);
  assign mem_addr = pc;
  // offsets and base are truncated or zero-extended to the pc width
  assign off_pc   = PC_WIDTH'(base_reg_offset);
  assign base_pc  = PC_WIDTH'(base);

  // next-pc select and stack op decode; controls only matter in EXEC
  always_comb begin
    next_pc = pc + PC_ONE;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    if (exec) begin
      if (pc_rst) begin
        flush   = 1'b1;
        next_pc = '0;
      end else if (pc_ld) begin
        case (jmp_mode_e'(jmp_mode))
          JMP_ABS: begin
            next_pc = off_pc;
            push    = lr_ld;
          end
          JMP_BASE: next_pc = base_pc + off_pc;
          JMP_RET: begin
            next_pc = stk_top + off_pc;
            pop     = 1'b1;
          end
          default: next_pc = pc + PC_ONE;
        endcase
      end
    end
  end

  instr_fetch_link_stack #(
    .PC_WIDTH    (PC_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_link_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_data (pc),
    .top       (stk_top),
    .ovf_det   (ovf_det),
    .unf_det   (unf_det)
  );

  // IDLE -> FETCH -> EXEC -> FETCH sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= '0;
      base        <= '0;
      instr       <= '0;
      arg         <= '0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      stack_ovf   <= 1'b0;
      stack_unf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state   <= ST_FETCH;
          mem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (mem_ack && mem_req) begin
            {instr, arg} <= mem_rdata;
            state        <= ST_EXEC;
            mem_req      <= 1'b0;
            instr_valid  <= 1'b1;
          end
        end
        ST_EXEC: begin
          state       <= ST_FETCH;
          mem_req     <= 1'b1;
          instr_valid <= 1'b0;
          pc          <= next_pc;
          // a new base only affects later instructions; jumps above used the old one
          if (pc_rst)           base <= '0;
          else if (base_reg_ld) base <= base_reg_data;
          if (ovf_det) stack_ovf <= 1'b1;
          if (unf_det) stack_unf <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          mem_req     <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: fetch timing, jumps, CALL/RET, stack flags, resets.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [7:0]  instr, arg, pc;
  logic        instr_valid;
  logic        pc_rst, pc_ld, base_reg_ld, lr_ld;
  logic [1:0]  jmp_mode;
  logic [7:0]  base_reg_offset, base_reg_data;
  logic        stack_ovf, stack_unf;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  instr_fetch #(.WIDTH(8), .PC_WIDTH(8), .STACK_DEPTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .instr           (instr),
    .arg             (arg),
    .instr_valid     (instr_valid),
    .pc              (pc),
    .pc_rst          (pc_rst),
    .pc_ld           (pc_ld),
    .jmp_mode        (jmp_mode),
    .base_reg_offset (base_reg_offset),
    .base_reg_ld     (base_reg_ld),
    .base_reg_data   (base_reg_data),
    .lr_ld           (lr_ld),
    .stack_ovf       (stack_ovf),
    .stack_unf       (stack_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_ctrl();
    pc_rst = 0; pc_ld = 0; jmp_mode = 2'b00; base_reg_offset = 0;
    base_reg_ld = 0; base_reg_data = 0; lr_ld = 0;
  endtask

  // one fetch+exec: expect fetch from a, ack after lat cycles, apply controls in EXEC
  task automatic step(input logic [7:0] a, input int lat, input logic prst, input logic pld,
                      input logic [1:0] mode, input logic [7:0] o, input logic bl,
                      input logic [7:0] bd, input logic lr);
    logic [7:0] e_instr, e_arg;
    e_instr = a ^ 8'h5A;
    e_arg   = ~a;
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) @(negedge clk);
    chk("req", mem_req, 1);
    chk("addr", mem_addr, a);
    for (int i = 1; i < lat; i++) begin
      pc_rst = 1; pc_ld = 1;  // must be ignored outside EXEC
      @(negedge clk);
      chk("req_hold", mem_req, 1);
      chk("addr_hold", mem_addr, a);
    end
    clr_ctrl();
    mem_ack   = 1;
    mem_rdata = {mem_addr ^ 8'h5A, ~mem_addr};
    @(negedge clk);
    mem_ack = 0;
    chk("valid", instr_valid, 1);
    chk("req_exec", mem_req, 0);
    chk("instr", instr, e_instr);
    chk("arg", arg, e_arg);
    chk("pc", pc, a);
    pc_rst = prst; pc_ld = pld; jmp_mode = mode; base_reg_offset = o;
    base_reg_ld = bl; base_reg_data = bd; lr_ld = lr;
    @(negedge clk);
    clr_ctrl();
    chk("valid_off", instr_valid, 0);
  endtask

  task automatic seq(input logic [7:0] a, input int lat);
    step(a, lat, 0, 0, 2'b00, 8'h00, 0, 8'h00, 0);
  endtask

  task automatic call(input logic [7:0] a, input logic [7:0] tgt);
    step(a, 1, 0, 1, 2'b00, tgt, 0, 8'h00, 1);
  endtask

  task automatic ret(input logic [7:0] a);
    step(a, 1, 0, 1, 2'b11, 8'h01, 0, 8'h00, 0);
  endtask

  initial begin
    clr_ctrl();
    mem_ack = 0;
    mem_rdata = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_arg", arg, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ovf", stack_ovf, 0);
    chk("rst_unf", stack_unf, 0);
    rst_n = 1;
    #1 chk("idle_req", mem_req, 0);

    // sequential fetch, then a slow ack
    seq(8'h00, 1); seq(8'h01, 1); seq(8'h02, 1); seq(8'h03, 1);
    seq(8'h04, 3);

    // CALL / RET
    call(8'h05, 8'h40);
    ret(8'h40);
    seq(8'h06, 1);

    // base load with base-relative jump in same EXEC uses old base (0): -> 0x20
    step(8'h07, 1, 0, 1, 2'b01, 8'h20, 1, 8'hF0, 0);
    // 0xF0 + 0x20 wraps to 0x10
    step(8'h20, 1, 0, 1, 2'b01, 8'h20, 0, 8'h00, 0);
    // reserved mode: plain increment
    step(8'h10, 2, 0, 1, 2'b10, 8'h33, 0, 8'h00, 0);

    // overflow: 5 nested calls into a 4-deep stack
    call(8'h11, 8'h50); call(8'h50, 8'h60); call(8'h60, 8'h70); call(8'h70, 8'h80);
    chk("ovf_before", stack_ovf, 0);
    call(8'h80, 8'h90);
    chk("ovf_after", stack_ovf, 1);
    ret(8'h90); ret(8'h71); ret(8'h61); ret(8'h51);
    chk("unf_before", stack_unf, 0);
    ret(8'h12);
    chk("unf_after", stack_unf, 1);
    seq(8'h01, 1);

    // pc_rst flushes stack and base, keeps flags
    call(8'h02, 8'h30);
    step(8'h30, 1, 1, 0, 2'b00, 8'h00, 0, 8'h00, 0);
    chk("ovf_kept", stack_ovf, 1);
    chk("unf_kept", stack_unf, 1);
    step(8'h00, 1, 0, 1, 2'b01, 8'h05, 0, 8'h00, 0);
    ret(8'h05);

    // async reset while a fetch is outstanding
    chk("mid_req", mem_req, 1);
    chk("mid_addr", mem_addr, 8'h01);
    #2 rst_n = 0;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_instr", instr, 0);
    chk("arst_arg", arg, 0);
    chk("arst_pc", pc, 0);
    chk("arst_ovf", stack_ovf, 0);
    chk("arst_unf", stack_unf, 0);
    mem_ack = 1;
    mem_rdata = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;  // stray ack stays high through IDLE
    #1 chk("idle2_req", mem_req, 0);
    @(negedge clk);
    mem_ack = 0;
    chk("post_req", mem_req, 1);
    chk("post_addr", mem_addr, 0);
    chk("post_instr", instr, 0);
    chk("post_valid", instr_valid, 0);
    seq(8'h00, 1);
    seq(8'h01, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
